// File: rtl/stream_unpacker.sv
// Width down-converter: accepts one IN_WIDTH word per handshake and replays it as
// N = IN_WIDTH/OUT_WIDTH chunks, least-significant first, flagging the final chunk.
module stream_unpacker #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 input__valid,
    input  logic [IN_WIDTH-1:0]  input__payload,
    output logic                 input__ready,
    output logic                 output__valid,
    output logic [OUT_WIDTH-1:0] output__payload,
    output logic                 output__last,
    input  logic                 output__ready
);

    localparam int N     = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || N < 2) begin : g_bad_params
            $error("stream_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH with at least two chunks");
        end
    endgenerate

    logic [N-1:0][OUT_WIDTH-1:0] word;
    logic [IDX_W-1:0]            idx;
    logic                        full;
    logic                        at_last;
    logic                        in_xfer;
    logic                        out_xfer;

    assign at_last  = (idx == LAST_IDX);
    assign in_xfer  = input__valid & input__ready;
    assign out_xfer = output__valid & output__ready;

    // Ready is combinational from output__ready so a new word can slot in on the
    // same cycle the last chunk of the current word leaves, avoiding a bubble.
    always_comb begin
        input__ready    = !full | (output__ready & at_last);
        output__valid   = full;
        output__payload = word[idx];
        output__last    = full & at_last;
    end

    // Later assignments win: a load overrides the last-chunk drain, and reset overrides both.
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            idx  <= '0;
            full <= 1'b0;
        end else begin
            if (out_xfer) begin
                if (at_last) begin
                    full <= 1'b0;
                    idx  <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (in_xfer) begin
                word <= input__payload;
                idx  <= '0;
                full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_unpacker.sv
// Bench for stream_unpacker: directed scenarios plus a random run, all checked every
// cycle against a queue-of-pending-chunks model; a second 16->4 instance covers parameters.
module tb_stream_unpacker;

    localparam int IW = 32;
    localparam int OW = 8;
    localparam int N  = IW / OW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_payload = '0;
    logic          in_ready;
    logic          out_valid;
    logic [OW-1:0] out_payload;
    logic          out_last;
    logic          out_ready = 1'b1;

    logic          s_in_valid = 1'b0;
    logic [15:0]   s_in_payload = '0;
    logic          s_in_ready;
    logic          s_out_valid;
    logic [3:0]    s_out_payload;
    logic          s_out_last;
    logic          s_out_ready = 1'b1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
    } chunk_t;

    chunk_t        model_q[$];
    logic [OW-1:0] obs_q[$];
    logic [IW-1:0] acc_words[$];
    logic [4:0]    s_log[$];
    int            last_count = 0;
    int            ready_mode = 0;
    int            pat_cnt = 0;

    always #5 clk = ~clk;

    stream_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst(rst),
        .input__valid(in_valid), .input__payload(in_payload), .input__ready(in_ready),
        .output__valid(out_valid), .output__payload(out_payload), .output__last(out_last),
        .output__ready(out_ready)
    );

    stream_unpacker #(.IN_WIDTH(16), .OUT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst),
        .input__valid(s_in_valid), .input__payload(s_in_payload), .input__ready(s_in_ready),
        .output__valid(s_out_valid), .output__payload(s_out_payload), .output__last(s_out_last),
        .output__ready(s_out_ready)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the chunks still owed for the current word; a word is only taken when
    // the queue is empty or its final chunk is leaving this cycle.
    always @(posedge clk) begin
        bit do_out;
        bit do_in;
        if (rst) begin
            model_q.delete();
        end else begin
            do_out = (model_q.size() > 0) && out_ready;
            do_in  = in_valid && (model_q.size() == 0 || (out_ready && model_q.size() == 1));
            if (do_out) void'(model_q.pop_front());
            if (do_in)
                for (int i = 0; i < N; i++)
                    model_q.push_back('{data: in_payload[i*OW +: OW], last: (i == N-1)});
            if (out_valid && out_ready) begin
                obs_q.push_back(out_payload);
                if (out_last) last_count++;
            end
            if (in_valid && in_ready) acc_words.push_back(in_payload);
            if (s_out_valid && s_out_ready) s_log.push_back({s_out_last, s_out_payload});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check_output("valid", 32'(out_valid), 32'(model_q.size() > 0));
            check_output("in_ready", 32'(in_ready),
                         32'(model_q.size() == 0 || (out_ready && model_q.size() == 1)));
            if (model_q.size() > 0) begin
                check_output("payload", 32'(out_payload), 32'(model_q[0].data));
                check_output("last", 32'(out_last), 32'(model_q[0].last));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        pat_cnt++;
        case (ready_mode)
            1:       out_ready = (pat_cnt % 3 == 0);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    task automatic apply_stimulus(input logic [IW-1:0] w);
        bit got = 0;
        in_valid   = 1'b1;
        in_payload = w;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!got) check_output("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!out_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) check_output("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input logic [OW-1:0] exp[$]);
        check_output({name, "_count"}, 32'(obs_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < obs_q.size(); i++)
            check_output(name, 32'(obs_q[i]), 32'(exp[i]));
        obs_q.delete();
    endtask

    initial begin
        int words_target;
        int nbad;
        bit got;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_valid", 32'(out_valid), 32'd0);
        check_output("rst_payload", 32'(out_payload), 32'd0);
        check_output("rst_last", 32'(out_last), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        apply_stimulus(32'h44332211);
        drain();
        check_log("single", '{8'h11, 8'h22, 8'h33, 8'h44});
        check_output("single_lasts", 32'(last_count), 32'd1);

        apply_stimulus(32'hDDCCBBAA);
        apply_stimulus(32'h04030201);
        drain();
        check_log("b2b", '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04});

        ready_mode = 1;
        apply_stimulus(32'h80FF7F00);
        drain();
        ready_mode = 0;
        check_log("bp", '{8'h00, 8'h7F, 8'hFF, 8'h80});

        apply_stimulus(32'h12345678);
        got = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (obs_q.size() >= 2) begin
                got = 1;
                break;
            end
        end
        if (!got) check_output("midrst_timeout", 32'd0, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("midrst_valid", 32'(out_valid), 32'd0);
        check_output("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        apply_stimulus(32'h0000AB00);
        drain();
        check_log("midrst", '{8'h78, 8'h56, 8'h00, 8'hAB, 8'h00, 8'h00});

        rst = 1'b1;
        in_valid = 1'b1;
        in_payload = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_output("rst_in_valid_ignored", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        s_in_valid = 1'b1;
        s_in_payload = 16'hA5C3;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s_in_ready) begin
                got = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        if (!got) check_output("small_timeout", 32'd0, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check_output("small_count", 32'(s_log.size()), 32'd4);
        if (s_log.size() == 4) begin
            check_output("small_c0", 32'(s_log[0]), 32'h03);
            check_output("small_c1", 32'(s_log[1]), 32'h0C);
            check_output("small_c2", 32'(s_log[2]), 32'h05);
            check_output("small_c3", 32'(s_log[3]), 32'h1A);
        end

        obs_q.delete();
        acc_words.delete();
        last_count = 0;
        words_target = 1000;
        ready_mode = 2;
        got = 0;
        for (int c = 0; c < 40000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_payload = $urandom;
            @(posedge clk);
            #1;
            if (acc_words.size() >= words_target) begin
                got = 1;
                break;
            end
        end
        in_valid = 1'b0;
        ready_mode = 0;
        if (!got) check_output("random_timeout", 32'd0, 32'd1);
        drain();
        check_output("rand_lasts", 32'(last_count), 32'(acc_words.size()));
        check_output("rand_chunks", 32'(obs_q.size()), 32'(acc_words.size() * N));
        nbad = 0;
        for (int i = 0; i < acc_words.size(); i++)
            for (int j = 0; j < N; j++)
                if (i*N + j >= obs_q.size() || obs_q[i*N + j] !== acc_words[i][j*OW +: OW])
                    nbad++;
        check_output("rand_stream", 32'(nbad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
